// File: rtl/alu_pkg.sv
// alu_pkg: op-code constants and condition-code bit positions
// shared by alu_core and alu_responder.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  // cc is packed as {ZF, SF, OF}
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ADD/SUB/AND/XOR with wrap-around result.
// Ports: fn, a, b in; res out; cc {ZF,SF,OF} out only with ALU_RESPONDER_CC_EN.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [1:0]       fn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
`ifdef ALU_RESPONDER_CC_EN
  ,
  output logic [2:0]       cc
`endif
);

  always_comb begin
    res = '0;
    unique case (1'b1)
      (fn == ALU_ADD): res = a + b;
      (fn == ALU_SUB): res = a - b;
      (fn == ALU_AND): res = a & b;
      (fn == ALU_XOR): res = a ^ b;
      default:         res = '0;
    endcase
  end

`ifdef ALU_RESPONDER_CC_EN
  logic sa;
  logic sb;
  logic sr;
  logic of;

  assign sa = a[WIDTH-1];
  assign sb = b[WIDTH-1];
  assign sr = res[WIDTH-1];

  // signed overflow: result sign disagrees with what the
  // operand signs force it to be
  always_comb begin
    of = 1'b0;
    unique case (1'b1)
      (fn == ALU_ADD): of = (sa == sb) && (sr != sa);
      (fn == ALU_SUB): of = (sa != sb) && (sr != sa);
      default:         of = 1'b0;
    endcase
  end

  always_comb begin
    cc        = '0;
    cc[CC_ZF] = (res == '0);
    cc[CC_SF] = sr;
    cc[CC_OF] = of;
  end
`endif

endmodule

// File: rtl/alu_responder.sv
// alu_responder: valid/ready ALU front end with a DEPTH-entry result FIFO.
// Ports: clk, rst (sync, active-high), req_valid/req_ready, fn, a, b,
// rsp_valid/rsp_ready, out, cc. Macro ALU_RESPONDER_CC_EN enables cc storage.
module alu_responder
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       fn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       cc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] core_res;
  logic [WIDTH-1:0] res_mem [DEPTH];

  // pointers wrap at DEPTH, which need not be a power of two
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign req_ready = (count < CW'(DEPTH));
  assign rsp_valid = (count != '0);
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

`ifdef ALU_RESPONDER_CC_EN
  logic [2:0] core_cc;
  logic [2:0] cc_mem [DEPTH];

  alu_core #(.WIDTH(WIDTH)) u_core (
    .fn  (fn),
    .a   (a),
    .b   (b),
    .res (core_res),
    .cc  (core_cc)
  );

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      cc_mem[wr_ptr] <= core_cc;
    end
  end

  assign cc = rsp_valid ? cc_mem[rd_ptr] : 3'b000;
`else
  alu_core #(.WIDTH(WIDTH)) u_core (
    .fn  (fn),
    .a   (a),
    .b   (b),
    .res (core_res)
  );

  assign cc = 3'b000;
`endif

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      res_mem[wr_ptr] <= core_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // empty FIFO presents zeros rather than stale entries
  assign out = rsp_valid ? res_mem[rd_ptr] : '0;

endmodule
